// File: rtl/cdm_pkg.sv
// Shared constants and types for the carry-disregard MAC accumulator.
package cdm_pkg;

    localparam int ACC_W_DEF = 24;   // default accumulator / result width
    localparam int CNT_W     = 8;    // beat counter width
    localparam int PROD_W    = 16;   // 8x8 product width
    localparam int EXACT_LSB = 4;    // product columns below this drop their carries

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [PROD_W-1:0] prod_t;

    localparam cnt_t COUNT_MAX = '1;  // beat count saturates here (255)

endpackage

// File: rtl/cdm8_40.sv
// 8x8 carry-disregard approximate multiplier. The four low result columns
// keep only the parity of their partial-product bits (carries discarded and
// never propagated upward); all higher columns are summed exactly.
module cdm8_40
    import cdm_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output prod_t      p
);

    localparam prod_t LOW_MASK = prod_t'((1 << EXACT_LSB) - 1);

    prod_t row;
    prod_t low_x;
    prod_t high_s;

    // Row-wise partial products: XOR the low columns, add the high columns.
    always_comb begin
        row    = '0;
        low_x  = '0;
        high_s = '0;
        for (int j = 0; j < 8; j++) begin
            row    = prod_t'(a & {8{b[j]}}) << j;
            low_x  = low_x ^ (row & LOW_MASK);
            high_s = high_s + (row & ~LOW_MASK);
        end
        p = high_s | low_x;
    end

endmodule

// File: rtl/cdm_mac_acc.sv
// Streaming dot-product accumulator built on the cdm8_40 approximate
// multiplier: S1 operand register, S2 product register, ACC group
// accumulator with a held output register. A pending unaccepted result
// freezes the whole pipeline.
module cdm_mac_acc
    import cdm_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int SAT_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output cnt_t             out_count,
    output logic             out_sat
);

    // {carry-out, sum} of accumulator plus zero-extended product
    function automatic logic [ACC_W:0] add_ext(input logic [ACC_W-1:0] acc_v,
                                               input prod_t            prod_v);
        return {1'b0, acc_v} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_v};
    endfunction

    // Clamp to all-ones on carry-out in saturating mode, else keep wrapped bits
    function automatic logic [ACC_W-1:0] sat_wrap(input logic [ACC_W:0] sum_v);
        if ((SAT_EN != 0) && sum_v[ACC_W])
            return '1;
        return sum_v[ACC_W-1:0];
    endfunction

    // Beat counter increment that sticks at COUNT_MAX
    function automatic cnt_t cnt_inc(input cnt_t c);
        return (c == COUNT_MAX) ? c : c + cnt_t'(1);
    endfunction

    logic             stall;
    logic             accept;

    logic [7:0]       a_p0;
    logic [7:0]       b_p0;
    logic             last_p0;
    logic             vld_p0;

    prod_t            prod_c;
    prod_t            prod_p1;
    logic             last_p1;
    logic             vld_p1;

    logic [ACC_W-1:0] acc_p2;
    cnt_t             cnt_p2;
    logic             sticky_p2;

    logic [ACC_W:0]   sum_c;
    logic [ACC_W-1:0] acc_nxt;
    cnt_t             cnt_nxt;
    logic             sticky_nxt;
    logic             fin_p1;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;
    assign fin_p1   = vld_p1 & last_p1;

    // ---- S1: operand capture ----
    // Operand data register, frozen while stalled
    always_ff @(posedge clk) begin
        if (!stall) begin
            a_p0 <= in_a;
            b_p0 <= in_b;
        end
    end

    // S1 valid / last; a beat only counts when the handshake completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
        end else if (!stall) begin
            vld_p0  <= accept;
            last_p0 <= in_last;
        end
    end

    cdm8_40 u_mul (
        .a (a_p0),
        .b (b_p0),
        .p (prod_c)
    );

    // ---- S2: product register ----
    // Approximate product data, frozen while stalled
    always_ff @(posedge clk) begin
        if (!stall) begin
            prod_p1 <= prod_c;
        end
    end

    // S2 valid / last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else if (!stall) begin
            vld_p1  <= vld_p0;
            last_p1 <= last_p0;
        end
    end

    // ---- ACC: group accumulation ----
    // Next accumulator, sticky overflow flag and count for the S2 beat
    always_comb begin
        sum_c      = add_ext(acc_p2, prod_p1);
        acc_nxt    = sat_wrap(sum_c);
        sticky_nxt = sticky_p2 | sum_c[ACC_W];
        cnt_nxt    = cnt_inc(cnt_p2);
    end

    // Accumulator state; a last beat hands its totals off and restarts at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p2    <= '0;
            cnt_p2    <= '0;
            sticky_p2 <= 1'b0;
        end else if (!stall && vld_p1) begin
            if (last_p1) begin
                acc_p2    <= '0;
                cnt_p2    <= '0;
                sticky_p2 <= 1'b0;
            end else begin
                acc_p2    <= acc_nxt;
                cnt_p2    <= cnt_nxt;
                sticky_p2 <= sticky_nxt;
            end
        end
    end

    // Result register; when not stalled any held result is being taken,
    // so a new group result can load on the same edge without a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else if (!stall) begin
            out_valid <= fin_p1;
            if (fin_p1) begin
                out_data  <= acc_nxt;
                out_count <= cnt_nxt;
                out_sat   <= sticky_nxt;
            end
        end
    end

endmodule

// File: tb/tb_cdm_mac_acc.sv
// Bench for cdm_mac_acc: three instances (24-bit saturating default,
// 16-bit saturating, 16-bit wrapping) share one input stream and one
// out_ready; results are scored against a behavioural group-sum model.
module tb_cdm_mac_acc;

    localparam longint MAX24 = 64'd16777215;
    localparam longint MAX16 = 64'd65535;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic in_last;
    logic out_ready;

    logic ir24, ir16s, ir16w;
    logic ov24, ov16s, ov16w;
    logic [23:0] od24;
    logic [15:0] od16s, od16w;
    logic [7:0] oc24, oc16s, oc16w;
    logic os24, os16s, os16w;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cdm_mac_acc u_d24 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir24),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov24),
        .out_ready(out_ready), .out_data(od24), .out_count(oc24), .out_sat(os24)
    );

    cdm_mac_acc #(.ACC_W(16), .SAT_EN(1)) u_d16s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16s),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov16s),
        .out_ready(out_ready), .out_data(od16s), .out_count(oc16s), .out_sat(os16s)
    );

    cdm_mac_acc #(.ACC_W(16), .SAT_EN(0)) u_d16w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16w),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov16w),
        .out_ready(out_ready), .out_data(od16w), .out_count(oc16w), .out_sat(os16w)
    );

    typedef struct {
        logic [23:0] d24;
        logic [15:0] d16s;
        logic [15:0] d16w;
        logic [7:0]  cnt;
        logic        s24;
        logic        s16s;
        logic        s16w;
    } res_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
    } vec_t;

    res_t   exp_q[$];
    longint m24, m16s, m16w;
    bit     st24, st16s, st16w;
    int     mcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Column-wise model: low 4 columns keep bit-count parity, others the full count.
    function automatic int cdm_model(input int a, input int b);
        int r;
        int n;
        r = 0;
        for (int c = 0; c < 15; c++) begin
            n = 0;
            for (int i = 0; i < 8; i++)
                if (c - i >= 0 && c - i < 8)
                    n += ((a >> i) & 1) * ((b >> (c - i)) & 1);
            if (c < 4) r += (n % 2) << c;
            else       r += n << c;
        end
        return r;
    endfunction

    task automatic model_clear();
        m24 = 0; m16s = 0; m16w = 0;
        st24 = 0; st16s = 0; st16w = 0;
        mcnt = 0;
    endtask

    task automatic model_accept(input int a, input int b, input bit last);
        longint s;
        int p;
        res_t r;
        p = cdm_model(a, b);
        mcnt++;
        s = m24 + p;  if (s > MAX24) begin st24 = 1;  s = MAX24; end  m24 = s;
        s = m16s + p; if (s > MAX16) begin st16s = 1; s = MAX16; end  m16s = s;
        s = m16w + p; if (s > MAX16) begin st16w = 1; s = s - 65536; end m16w = s;
        if (last) begin
            r.d24  = m24[23:0];
            r.d16s = m16s[15:0];
            r.d16w = m16w[15:0];
            r.cnt  = 8'((mcnt > 255) ? 255 : mcnt);
            r.s24  = st24;
            r.s16s = st16s;
            r.s16w = st16w;
            exp_q.push_back(r);
            model_clear();
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_beat(input int a, input int b, input bit last);
        int w;
        in_valid = 1'b1;
        in_a     = 8'(a);
        in_b     = 8'(b);
        in_last  = last;
        w = 0;
        #1;
        while (!ir24 && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!ir24) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=in_ready_low required=accept_within_200");
            in_valid = 1'b0;
        end else begin
            model_accept(a, b, last);
            @(negedge clk);
        end
    endtask

    task automatic wait_out(output bit got);
        got = 0;
        for (int w = 0; w < 12; w++) begin
            #3;
            if (ov24) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Scoreboard: every result handshake is compared against the model queue.
    always @(negedge clk) begin
        res_t e;
        #2;
        if (rst_n === 1'b1 && ov24 === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=result(%0h) required=none", od24);
            end else begin
                e = exp_q.pop_front();
                check("sb_d24",  od24,  e.d24);
                check("sb_d16s", od16s, e.d16s);
                check("sb_d16w", od16w, e.d16w);
                check("sb_cnt",  oc24,  e.cnt);
                check("sb_s24",  os24,  e.s24);
                check("sb_s16s", os16s, e.s16s);
                check("sb_s16w", os16w, e.s16w);
                check("sb_ov16s", ov16s, 1);
                check("sb_ov16w", ov16w, 1);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        bit   got;
        int   c0;
        int   a1, b1, a2, b2;
        int   len;
        bit   done;

        tbl[0] = '{8'h01, 8'h01, 16'h0001};
        tbl[1] = '{8'h03, 8'h03, 16'h0005};
        tbl[2] = '{8'hFF, 8'hFF, 16'hFDD5};
        tbl[3] = '{8'h10, 8'h10, 16'h0100};
        tbl[4] = '{8'h0F, 8'h0F, 16'h00B5};
        tbl[5] = '{8'h5A, 8'h01, 16'h005A};
        tbl[6] = '{8'h02, 8'h03, 16'h0006};
        tbl[7] = '{8'h07, 8'h06, 16'h0012};

        model_clear();
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        check("rst_out_valid", ov24, 0);
        check("rst_out_data",  od24, 0);
        check("rst_out_count", oc24, 0);
        check("rst_out_sat",   os24, 0);
        check("rst_in_ready",  ir24, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero multiplicand group: timing of the single result pulse
        for (int i = 0; i < 4; i++) send_beat(0, 8'h5A, i == 3);
        in_valid = 1'b0;
        #3 check("z4_ov_e0", ov24, 0);
        @(negedge clk); #3 check("z4_ov_e1", ov24, 0);
        @(negedge clk); #3;
        check("z4_ov_e2", ov24, 1);
        check("z4_data",  od24, 0);
        check("z4_count", oc24, 4);
        check("z4_sat",   os24, 0);
        @(negedge clk); #3 check("z4_ov_e3", ov24, 0);

        // Table of single-beat groups against hand-computed approximate products
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            send_beat(tbl[t].a, tbl[t].b, 1);
            in_valid = 1'b0;
            wait_out(got);
            check($sformatf("tbl%0d_got", t), got, 1);
            check($sformatf("tbl%0d_d24", t), od24, {8'h00, tbl[t].prod});
            check($sformatf("tbl%0d_d16s", t), od16s, tbl[t].prod);
            check($sformatf("tbl%0d_cnt", t), oc24, 1);
            check($sformatf("tbl%0d_sat", t), os24, 0);
        end

        // Zero-B group then single beat, results back-to-back
        @(negedge clk);
        for (int i = 0; i < 3; i++) send_beat($urandom_range(255), 0, i == 2);
        send_beat(1, 1, 1);
        in_valid = 1'b0;
        #3 check("b2b_ov_pre", ov24, 0);
        @(negedge clk); #3;
        check("b2b_ov1",  ov24, 1);
        check("b2b_d1",   od24, 0);
        check("b2b_cnt1", oc24, 3);
        @(negedge clk); #3;
        check("b2b_ov2",  ov24, 1);
        check("b2b_d2",   od24, cdm_model(1, 1));
        check("b2b_cnt2", oc24, 1);
        drain();

        // Back-pressure: result pending while a 10-beat group streams in
        @(negedge clk);
        out_ready = 1'b0;
        send_beat(8'h21, 8'h13, 1);
        in_valid = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send_beat($urandom_range(255), $urandom_range(255), i == 9);
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(negedge clk);
                #3;
                check("bp_in_ready_low", ir24, 0);
                check("bp_ov_held",      ov24, 1);
                repeat (8) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // 300 beats of FF*FF: saturation, wrap, count clamp, full throughput
        @(negedge clk);
        c0 = cyc;
        for (int i = 0; i < 300; i++) send_beat(8'hFF, 8'hFF, i == 299);
        check("long_cycles", cyc - c0, 300);
        in_valid = 1'b0;
        wait_out(got);
        check("long_got",  got, 1);
        check("long_d16s", od16s, 16'hFFFF);
        check("long_s16s", os16s, 1);
        check("long_cnt",  oc16s, 255);
        check("long_d16w", od16w, 16'h759C);
        check("long_s16w", os16w, 1);
        check("long_d24",  od24, 24'hFFFFFF);
        check("long_s24",  os24, 1);
        drain();

        // Reset in the middle of a group
        @(negedge clk);
        for (int i = 0; i < 3; i++) send_beat(8'hC3, 8'h7E, 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mrst_ov",       ov24, 0);
        check("mrst_count",    oc24, 0);
        check("mrst_in_ready", ir24, 1);
        exp_q.delete();
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        a1 = $urandom_range(255); b1 = $urandom_range(255);
        a2 = $urandom_range(255); b2 = $urandom_range(255);
        send_beat(a1, b1, 0);
        send_beat(a2, b2, 1);
        in_valid = 1'b0;
        wait_out(got);
        check("mrst_got",   got, 1);
        check("mrst_count2", oc24, 2);
        check("mrst_sum",   od24, cdm_model(a1, b1) + cdm_model(a2, b2));
        drain();

        // Random groups with bubbles and random back-pressure
        @(negedge clk);
        done = 0;
        fork
            begin
                for (int g = 0; g < 16; g++) begin
                    len = $urandom_range(1, 6);
                    for (int i = 0; i < len; i++) begin
                        if ($urandom_range(3) == 0) begin
                            in_valid = 1'b0;
                            @(negedge clk);
                        end
                        send_beat($urandom_range(255), $urandom_range(255), i == len - 1);
                    end
                end
                in_valid = 1'b0;
                done = 1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
